// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg: phase encodings, requester indices and width defaults for the sample RAM controller
package ram_access_ctrl_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int PHASE_W_DEF = 3;
  localparam int REQ_LD = 0;
  localparam int REQ_SGD = 1;
  localparam int REQ_WB = 2;
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_LOAD  = 3'd1,
    PH_TRAIN = 3'd2,
    PH_FLUSH = 3'd3,
    PH_DONE  = 3'd4
  } phase_e;
endpackage

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: requester handshakes, RAM strobes and phase status of the sample RAM controller
interface ram_access_ctrl_if
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
);
  logic start;
  logic [ADDR_WIDTH-1:0] data_points;
  logic ld_req, ld_gnt, sgd_req, sgd_gnt, wb_req, wb_gnt, sgd_done;
  logic [ADDR_WIDTH-1:0] ld_addr, sgd_addr, wb_addr, ram_addr;
  logic ram_we, ram_oe, ld_en, sgd_en, err;
  logic [PHASE_W-1:0] phase;
  modport slave (
    input start, data_points, ld_req, ld_addr, sgd_req, sgd_addr, wb_req, wb_addr, sgd_done,
    output ld_gnt, sgd_gnt, wb_gnt, ram_addr, ram_we, ram_oe, ld_en, sgd_en, phase, err
  );
  modport master (
    output start, data_points, ld_req, ld_addr, sgd_req, sgd_addr, wb_req, wb_addr, sgd_done,
    input ld_gnt, sgd_gnt, wb_gnt, ram_addr, ram_we, ram_oe, ld_en, sgd_en, phase, err
  );
endinterface

// File: rtl/ram_access_ctrl_rr_arb2.sv
// ram_rr_arb2: two-way alternating arbiter between SGD reads (a) and writebacks (b)
module ram_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  // alt_q remembers whether b won last; cleared so b wins the first contest
  logic alt_q;
  assign gnt_b = en && req_b && (!req_a || !alt_q);
  assign gnt_a = en && req_a && (!req_b || alt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) alt_q <= 1'b0;
    else if (clr) alt_q <= 1'b0;
    else if (gnt_a || gnt_b) alt_q <= gnt_b;
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: phase FSM and one-grant-per-cycle arbiter for the shared sample RAM
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input logic CLK,
  input logic RST,
  ram_access_ctrl_if.slave bus
);
  phase_e state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] dp_q, dp_d, addr_q, addr_d;
  logic [2:0] gnt_q, gnt_d;
  logic we_q, we_d, oe_q, oe_d, err_q, err_d, ld_en_q, sgd_en_q;
  logic load_full, ld_in, arb_sgd, arb_wb;
  assign load_full = cnt_q == {1'b0, dp_q};
  assign ld_in = bus.ld_addr < dp_q;
  ram_rr_arb2 u_arb (
    .clk  (CLK),
    .rst_n(RST),
    .en   (state_q == PH_TRAIN && !bus.sgd_done),
    .clr  (state_q != PH_TRAIN),
    .req_a(bus.sgd_req),
    .req_b(bus.wb_req),
    .gnt_a(arb_sgd),
    .gnt_b(arb_wb)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state_q <= PH_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_IDLE, PH_DONE: if (bus.start && bus.data_points != '0) state_d = PH_LOAD;
      PH_LOAD: if (load_full) state_d = PH_TRAIN;
      PH_TRAIN: if (bus.sgd_done) state_d = PH_FLUSH;
      PH_FLUSH: if (!bus.wb_req) state_d = PH_DONE;
      default: state_d = PH_IDLE;
    endcase
  end
  always_comb begin
    gnt_d = '0;
    we_d = 1'b0;
    oe_d = 1'b0;
    addr_d = addr_q;
    err_d = err_q;
    dp_d = dp_q;
    cnt_d = cnt_q;
    case (state_q)
      PH_IDLE, PH_DONE: if (bus.start) begin
        err_d = bus.data_points == '0;
        if (bus.data_points != '0) begin
          dp_d = bus.data_points;
          cnt_d = '0;
        end
      end
      PH_LOAD: if (bus.ld_req && !load_full) begin
        // out-of-range writes are still granted so the loader never stalls
        gnt_d[REQ_LD] = 1'b1;
        addr_d = bus.ld_addr;
        we_d = ld_in;
        err_d = err_q || !ld_in;
        if (ld_in) cnt_d = cnt_q + 1'b1;
      end
      PH_TRAIN: begin
        err_d = err_q || bus.ld_req;
        if (arb_sgd) begin
          gnt_d[REQ_SGD] = 1'b1;
          addr_d = bus.sgd_addr;
          oe_d = 1'b1;
        end else if (arb_wb) begin
          gnt_d[REQ_WB] = 1'b1;
          addr_d = bus.wb_addr;
          we_d = 1'b1;
        end
      end
      PH_FLUSH: if (bus.wb_req) begin
        gnt_d[REQ_WB] = 1'b1;
        addr_d = bus.wb_addr;
        we_d = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      gnt_q <= '0;
      we_q <= 1'b0;
      oe_q <= 1'b0;
      addr_q <= '0;
      err_q <= 1'b0;
      dp_q <= '0;
      cnt_q <= '0;
      ld_en_q <= 1'b0;
      sgd_en_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      we_q <= we_d;
      oe_q <= oe_d;
      addr_q <= addr_d;
      err_q <= err_d;
      dp_q <= dp_d;
      cnt_q <= cnt_d;
      ld_en_q <= state_d == PH_LOAD;
      sgd_en_q <= state_d == PH_TRAIN || state_d == PH_FLUSH;
    end
  assign bus.ld_gnt = gnt_q[REQ_LD];
  assign bus.sgd_gnt = gnt_q[REQ_SGD];
  assign bus.wb_gnt = gnt_q[REQ_WB];
  assign bus.ram_we = we_q;
  assign bus.ram_oe = oe_q;
  assign bus.ram_addr = addr_q;
  assign bus.err = err_q;
  assign bus.ld_en = ld_en_q;
  assign bus.sgd_en = sgd_en_q;
  assign bus.phase = PHASE_W'(state_q);
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: table-driven and directed checks of the sample RAM controller
module tb_ram_access_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int checks = 0;
  int errors = 0;
  ram_access_ctrl_if bus ();
  ram_access_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    logic ld_req, sgd_req, wb_req, done;
    logic [11:0] ld_addr, sgd_addr, wb_addr;
    logic [2:0] gnt;
    logic we, oe, ld_en, sgd_en, err;
    logic [11:0] addr;
    logic [2:0] ph;
  } vec_t;
  vec_t v[11];
  function automatic vec_t mk(logic lr, int la, logic sr, int sa, logic wr, int wa, logic d,
                              logic [2:0] g, logic we, logic oe, int ad, int ph,
                              logic le, logic se, logic er);
    vec_t r;
    r.ld_req = lr; r.ld_addr = la[11:0]; r.sgd_req = sr; r.sgd_addr = sa[11:0];
    r.wb_req = wr; r.wb_addr = wa[11:0]; r.done = d; r.gnt = g; r.we = we; r.oe = oe;
    r.addr = ad[11:0]; r.ph = ph[2:0]; r.ld_en = le; r.sgd_en = se; r.err = er;
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic lr, input int la, input logic sr, input int sa,
                       input logic wr, input int wa, input logic d);
    bus.ld_req = lr; bus.ld_addr = la[11:0]; bus.sgd_req = sr; bus.sgd_addr = sa[11:0];
    bus.wb_req = wr; bus.wb_addr = wa[11:0]; bus.sgd_done = d;
  endtask
  task automatic go(input int dp);
    bus.start = 1'b1;
    bus.data_points = dp[11:0];
    step();
    bus.start = 1'b0;
  endtask
  function automatic logic [2:0] gnts();
    return {bus.wb_gnt, bus.sgd_gnt, bus.ld_gnt};
  endfunction
  initial begin
    bus.start = 1'b0;
    bus.data_points = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    v[0]  = mk(1, 0, 0, 0, 0, 0, 0,  3'b001, 1, 0, 0, 1, 1, 0, 0);
    v[1]  = mk(1, 1, 0, 0, 0, 0, 0,  3'b001, 1, 0, 1, 1, 1, 0, 0);
    v[2]  = mk(1, 2, 0, 0, 0, 0, 0,  3'b001, 1, 0, 2, 1, 1, 0, 0);
    v[3]  = mk(0, 0, 0, 0, 0, 0, 0,  3'b000, 0, 0, 2, 2, 0, 1, 0);
    v[4]  = mk(0, 0, 1, 7, 1, 9, 0,  3'b100, 1, 0, 9, 2, 0, 1, 0);
    v[5]  = mk(0, 0, 1, 7, 1, 9, 0,  3'b010, 0, 1, 7, 2, 0, 1, 0);
    v[6]  = mk(0, 0, 1, 7, 1, 9, 0,  3'b100, 1, 0, 9, 2, 0, 1, 0);
    v[7]  = mk(0, 0, 1, 7, 1, 9, 0,  3'b010, 0, 1, 7, 2, 0, 1, 0);
    v[8]  = mk(0, 0, 1, 7, 1, 9, 1,  3'b000, 0, 0, 7, 3, 0, 1, 0);
    v[9]  = mk(0, 0, 1, 7, 1, 10, 1, 3'b100, 1, 0, 10, 3, 0, 1, 0);
    v[10] = mk(0, 0, 1, 7, 0, 10, 1, 3'b000, 0, 0, 10, 4, 0, 0, 0);
    #12;
    chk("rst_gnt", 32'(gnts()), 0);
    chk("rst_weoe", {bus.ram_we, bus.ram_oe}, 0);
    chk("rst_addr", 32'(bus.ram_addr), 0);
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_en_err", {bus.ld_en, bus.sgd_en, bus.err}, 0);
    RST = 1'b1;
    step();
    go(0);
    chk("idle_dp0_err", 32'(bus.err), 1);
    chk("idle_dp0_phase", 32'(bus.phase), 0);
    go(3);
    chk("start3_phase", 32'(bus.phase), 1);
    chk("start3_err", 32'(bus.err), 0);
    chk("start3_lden", 32'(bus.ld_en), 1);
    for (int i = 0; i < 11; i++) begin
      drive(v[i].ld_req, 32'(v[i].ld_addr), v[i].sgd_req, 32'(v[i].sgd_addr),
            v[i].wb_req, 32'(v[i].wb_addr), v[i].done);
      step();
      chk($sformatf("v%0d_gnt", i), 32'(gnts()), 32'(v[i].gnt));
      chk($sformatf("v%0d_weoe", i), {bus.ram_we, bus.ram_oe}, {v[i].we, v[i].oe});
      chk($sformatf("v%0d_addr", i), 32'(bus.ram_addr), 32'(v[i].addr));
      chk($sformatf("v%0d_phase", i), 32'(bus.phase), 32'(v[i].ph));
      chk($sformatf("v%0d_en", i), {bus.ld_en, bus.sgd_en}, {v[i].ld_en, v[i].sgd_en});
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(v[i].err));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    go(0);
    chk("done_dp0_err", 32'(bus.err), 1);
    chk("done_dp0_phase", 32'(bus.phase), 4);
    go(2);
    chk("done_start_err", 32'(bus.err), 0);
    chk("done_start_phase", 32'(bus.phase), 1);
    drive(1, 5, 0, 0, 0, 0, 0);
    step();
    chk("oob_gnt", 32'(gnts()), 1);
    chk("oob_we", 32'(bus.ram_we), 0);
    chk("oob_err", 32'(bus.err), 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    bus.start = 1'b1;
    bus.data_points = 12'd7;
    step();
    bus.start = 1'b0;
    chk("ld0_gnt_we", {gnts(), bus.ram_we}, {3'b001, 1'b1});
    drive(1, 1, 0, 0, 0, 0, 0);
    step();
    chk("ld1_gnt_we", {gnts(), bus.ram_we}, {3'b001, 1'b1});
    chk("ld1_phase", 32'(bus.phase), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("ld_end_phase", 32'(bus.phase), 2);
    drive(0, 0, 0, 0, 1, 4, 0);
    step();
    chk("wb_only_gnt", 32'(gnts()), 4);
    chk("wb_only_addr", 32'(bus.ram_addr), 4);
    drive(0, 0, 1, 3, 1, 4, 0);
    step();
    chk("alt_after_wb", 32'(gnts()), 2);
    chk("alt_after_wb_oe", {bus.ram_we, bus.ram_oe}, 1);
    drive(0, 0, 1, 3, 0, 0, 0);
    step();
    chk("pre_rst_sgd_gnt", 32'(gnts()), 2);
    #1 RST = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnts()), 0);
    chk("async_rst_weoe", {bus.ram_we, bus.ram_oe}, 0);
    chk("async_rst_phase", 32'(bus.phase), 0);
    chk("async_rst_en_err", {bus.ld_en, bus.sgd_en, bus.err}, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #3 RST = 1'b1;
    go(4);
    chk("post_rst_phase", 32'(bus.phase), 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    bus.data_points = 12'd1;
    RST = 1'b0;
    #1 RST = 1'b1;
    go(1);
    chk("dp1_phase", 32'(bus.phase), 1);
    step();
    chk("dp1_gnt", 32'(gnts()), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("dp1_phase_train", 32'(bus.phase), 2);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("train_ld_gnt", 32'(gnts()), 0);
    chk("train_ld_err", 32'(bus.err), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Sequences and arbitrates the single shared sample RAM between three requesters:
  - serial loader (writes),
  - SGD engine (reads),
  - SGD result writeback (writes).
- Replaces ad-hoc combinational steering at top level with a registered phase FSM (LOAD → TRAIN → FLUSH → DONE) and a one-grant-per-cycle arbiter driving RAM address/we/oe.

Parameters:
- ADDR_WIDTH, 12, RAM address width; also width of the data-point count.
- PHASE_W, 3, width of phase output.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- data_points  input  ADDR_WIDTH  number of samples to load; sampled on accepted start.
- ld_req  input  1  loader write request.
- ld_addr  input  ADDR_WIDTH  loader write address.
- ld_gnt  output  1  loader grant.
- sgd_req  input  1  SGD read request.
- sgd_addr  input  ADDR_WIDTH  SGD read address.
- sgd_gnt  output  1  SGD grant.
- wb_req  input  1  writeback request.
- wb_addr  input  ADDR_WIDTH  writeback address.
- wb_gnt  output  1  writeback grant.
- sgd_done  input  1  SGD engine finished all epochs (level).
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.
- ld_en  output  1  loader enable (high only in LOAD).
- sgd_en  output  1  SGD enable (high in TRAIN and FLUSH).
- phase  output  PHASE_W  0 IDLE, 1 LOAD, 2 TRAIN, 3 FLUSH, 4 DONE.
- err  output  1  sticky error flag.

Behaviour:
- All outputs registered.
- Reset (RST=0, any time, async): every output 0, phase=IDLE, load count=0, latched data_points=0, alternation bit=0. A run in progress is abandoned; no RAM access in the reset cycle.
- Request protocol: a requester holds req and addr stable until it sees gnt. A grant lasts exactly one cycle. Request sampled at edge n → gnt, ram_addr, we/oe valid after edge n+1 (latency 1). req still high in the cycle gnt is seen = new request; back-to-back grants every cycle are allowed.
- At most one of ld_gnt/sgd_gnt/wb_gnt is high per cycle. When no grant is issued: ram_we=ram_oe=0 and ram_addr holds its last value.
- IDLE: ignores all requests.
  - start with data_points≠0 → latch data_points, clear count, clear err, go to LOAD.
  - start with data_points=0 → set err, stay IDLE.
- LOAD: ld_en=1; only ld_req is served.
  - ld_addr < latched data_points: grant with ram_we=1, ram_oe=0, ram_addr=ld_addr; count+1.
  - ld_addr ≥ latched data_points: grant still issued (so the loader is not stalled), but ram_we=0, err set, count unchanged.
  - The cycle the count reaches data_points: transition to TRAIN; ld_en drops the next cycle.
  - sgd_req/wb_req in LOAD are ignored.
- TRAIN: sgd_en=1.
  - sgd read: ram_oe=1, ram_we=0.
  - wb write: ram_we=1, ram_oe=0.
  - Both requesting: the one not granted last time wins (alternation bit; wb wins first after entering TRAIN).
  - Only one requesting: it wins, and the alternation bit is updated to record it.
  - ld_req in TRAIN: no grant; err set.
  - sgd_done=1 → FLUSH, even if a request is pending. A grant already issued completes.
- FLUSH: sgd_en=1; only wb_req is served (sgd_req ignored). First cycle with wb_req=0 → DONE.
- DONE: ld_en=sgd_en=0, no grants, err holds. start → LOAD with fresh latch/clear, same rules as IDLE, including the data_points=0 case.
- start while in LOAD/TRAIN/FLUSH: ignored.
- Count width ADDR_WIDTH+1 so data_points=2^ADDR_WIDTH−1 never wraps.

Decomposition:
- Shared package holds:
  - phase encodings (IDLE=0, LOAD=1, TRAIN=2, FLUSH=3, DONE=4),
  - requester index constants (LD=0, SGD=1, WB=2),
  - ADDR_WIDTH default.
- One natural sub-module, ram_rr_arb2: 2-way alternating arbiter for sgd/wb with the alternation register. The FSM, counter and output registers stay in the top.

Test Plan:
- Reset mid-TRAIN with sgd_req=1 → within the same cycle all grants/we/oe=0, phase=0; after release, start with data_points=4 → phase=1.
- start, data_points=3; ld_req held with addresses 0,1,2 → ld_gnt on 3 consecutive cycles, ram_we=1, ram_addr 0,1,2 each one cycle after request; phase=2 the cycle after the third grant.
- LOAD with data_points=2, ld_addr=5 → ld_gnt=1, ram_we=0, err=1, count unchanged; then addrs 0,1 complete load normally.
- TRAIN with sgd_req and wb_req both held 4 cycles, sgd_addr=7, wb_addr=9 → grants wb,sgd,wb,sgd; ram_addr 9,7,9,7 with we/oe 10,01,10,01.
- sgd_done=1 while wb_req pending → phase=3, wb grants continue, sgd_req gets no grant; wb_req=0 → phase=4, sgd_en=0.
- start with data_points=0 in IDLE → err=1, phase stays 0; start from DONE with data_points=1 → err cleared, phase=1.
